vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator. Next generation of the fixed 640x480 sync counter.
//  Adds: any resolution/porch set, selectable sync polarity, integer pixel-clock divider
//  (pixel strobe), fully registered outputs aligned to the counters, line/frame start pulses
//  and a frame counter. Feeds the pixel/colour pipeline and the VGA pins in the display path.
// PARAMETERS
//  H_DISP   640  active pixels per line
//  H_FP     16   horizontal front porch (pixels)
//  H_SYNC   96   hsync pulse width (pixels)
//  H_BP     48   horizontal back porch (pixels, >=1)
//  V_DISP   480  active lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vsync pulse width (lines)
//  V_BP     33   vertical back porch (lines, >=1)
//  HS_POL   0    hsync active level (0 = active-low pulse)
//  VS_POL   0    vsync active level
//  CLK_DIV  1    pclk cycles per pixel step (>=1)
//  CNT_W    10   counter width; must hold H_TOTAL-1 and V_TOTAL-1
//  FC_W     8    frame counter width
// PORTS
//  pclk         in   1      clock; every register on rising edge
//  reset        in   1      synchronous, active-high reset
//  pix_en       out  1      high for the one pclk cycle after each pixel step
//  h_cnt        out  CNT_W  raw horizontal position 0..H_TOTAL-1
//  v_cnt        out  CNT_W  raw vertical position 0..V_TOTAL-1
//  x            out  CNT_W  h_cnt when valid, else 0
//  y            out  CNT_W  v_cnt when valid, else 0
//  valid        out  1      h_cnt<H_DISP && v_cnt<V_DISP
//  hsync        out  1      horizontal sync, level per HS_POL
//  vsync        out  1      vertical sync, level per VS_POL
//  vblank       out  1      v_cnt>=V_DISP
//  line_start   out  1      pix_en && h_cnt==0
//  frame_start  out  1      pix_en && h_cnt==0 && v_cnt==0
//  frame_cnt    out  FC_W   frames started since reset, wraps modulo 2^FC_W
// BEHAVIOUR
//  - H_TOTAL=H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Reset: h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, frame_cnt=all ones, pix_en=0, valid=0, x=y=0,
//    vblank=1, line_start=frame_start=0, hsync=~HS_POL, vsync=~VS_POL, divider cleared.
//  - Step: counting edges from the first edge with reset low, a pixel step occurs on edges
//    CLK_DIV, 2*CLK_DIV, ... At CLK_DIV=1, every edge. The first step enters (0,0).
//  - At a step, h advances mod H_TOTAL. v advances mod V_TOTAL only when h wraps.
//    All outputs are registered and show the new position's decode in the same cycle
//    (zero skew between h_cnt/v_cnt and every derived output).
//  - Between steps, all outputs hold. pix_en, line_start and frame_start are 1 pclk wide.
//  - hsync is active iff H_DISP+H_FP <= h_cnt <= H_DISP+H_FP+H_SYNC-1.
//  - vsync is active iff V_DISP+V_FP <= v_cnt <= V_DISP+V_FP+V_SYNC-1.
//    vsync changes on the step that enters h_cnt==0.
//  - frame_cnt increments in the cycle frame_start is high (first frame reads 0).
//    It wraps all-ones -> 0.
//  - Reset mid-operation: the next cycle shows reset values. The divider restarts, and
//    the first step after release enters (0,0) with frame_start=1.
//  - Reset wins over a coincident step.
// TESTING
//  Small bench params: H 8/2/3/2 (H_TOTAL 15), V 4/1/2/1 (V_TOTAL 8).
//  1 CLK_DIV=1, release reset -> next cycle h=0,v=0,valid=1,frame_start=1,line_start=1,
//    frame_cnt=0, hsync=vsync=1.
//  2 CLK_DIV=1, HS_POL=0 -> hsync=0 exactly for h_cnt 10..12 (3 cycles) each line;
//    valid=0 for h_cnt>=8.
//  3 CLK_DIV=2 -> pix_en every 2nd cycle, outputs hold between, line=30 pclk, frame=240 pclk.
//  4 CLK_DIV=1, VS_POL=1 -> vsync=1 for v_cnt 5..6 (30 cycles), vblank=1 for v 4..7,
//    frame_start every 120 cycles.
//  5 Run 257 frames, FC_W=8 -> frame_cnt reads 255 then 0 on frame_start.
//  6 reset 1 cycle at (h=5,v=2) -> next cycle h=14,v=7,valid=0, syncs inactive;
//    then (0,0) with frame_start=1, frame_cnt=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel strobe, registered
// sync/blank decode aligned to the counters, line/frame start pulses and a frame counter.
module vga_timing_gen #(
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CLK_DIV = 1,
    parameter int CNT_W   = 10,
    parameter int FC_W    = 8
) (
    input  logic             pclk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             vblank,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISP + V_FP + V_SYNC - 1);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic [FC_W-1:0]  fc_q;
    logic             step, h_wrap, origin_d, valid_d;
    logic             pix_q, ls_q, fs_q, valid_q, hs_q, hs_d, vs_q, vs_d, vb_q, vb_d;

    // Decode is taken from the next position so outputs change in the same cycle as the counters.
    always_comb begin
        step     = div_q == DIV_LAST;
        div_d    = step ? '0 : div_q + 1'b1;
        h_wrap   = h_q == H_LAST;
        h_d      = h_wrap ? '0 : h_q + 1'b1;
        v_d      = !h_wrap ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
        origin_d = h_d == '0 && v_d == '0;
        valid_d  = h_d < H_ACT && v_d < V_ACT;
        x_d      = valid_d ? h_d : '0;
        y_d      = valid_d ? v_d : '0;
        vb_d     = v_d >= V_ACT;
        hs_d     = (h_d >= HS_BEG && h_d <= HS_END) ? HS_POL : ~HS_POL;
        vs_d     = (v_d >= VS_BEG && v_d <= VS_END) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '1;
            pix_q   <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            valid_q <= 1'b0;
            vb_q    <= 1'b1;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
        end else begin
            div_q <= div_d;
            pix_q <= step;
            ls_q  <= step && h_d == '0;
            fs_q  <= step && origin_d;
            if (step) begin
                h_q     <= h_d;
                v_q     <= v_d;
                x_q     <= x_d;
                y_q     <= y_d;
                valid_q <= valid_d;
                vb_q    <= vb_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                if (origin_d) fc_q <= fc_q + 1'b1;
            end
        end
    end

    assign pix_en      = pix_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign x           = x_q;
    assign y           = y_q;
    assign valid       = valid_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign vblank      = vb_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of three small raster instances (divide-by-1 low syncs,
// divide-by-2, active-high vsync) covering reset, decode, frame counter wrap and mid-run reset.
module tb_vga_timing_gen;
    logic pclk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    logic       pe0, v0, hs0, vs0, vb0, ls0, fs0;
    logic [3:0] h0, vc0, x0, y0;
    logic [7:0] fc0;
    logic       pe1, v1, hs1, vs1, vb1, ls1, fs1;
    logic [3:0] h1, vc1, x1, y1;
    logic [7:0] fc1;
    logic       pe2, v2, hs2, vs2, vb2, ls2, fs2;
    logic [3:0] h2, vc2, x2, y2;
    logic [7:0] fc2;

    vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_DISP(4), .V_FP(1), .V_SYNC(2),
        .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .CNT_W(4), .FC_W(8)) u0 (
        .pclk(pclk), .reset(reset), .pix_en(pe0), .h_cnt(h0), .v_cnt(vc0), .x(x0), .y(y0),
        .valid(v0), .hsync(hs0), .vsync(vs0), .vblank(vb0), .line_start(ls0),
        .frame_start(fs0), .frame_cnt(fc0));

    vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_DISP(4), .V_FP(1), .V_SYNC(2),
        .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .CNT_W(4), .FC_W(8)) u1 (
        .pclk(pclk), .reset(reset), .pix_en(pe1), .h_cnt(h1), .v_cnt(vc1), .x(x1), .y(y1),
        .valid(v1), .hsync(hs1), .vsync(vs1), .vblank(vb1), .line_start(ls1),
        .frame_start(fs1), .frame_cnt(fc1));

    vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_DISP(4), .V_FP(1), .V_SYNC(2),
        .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(1), .CNT_W(4), .FC_W(8)) u2 (
        .pclk(pclk), .reset(reset), .pix_en(pe2), .h_cnt(h2), .v_cnt(vc2), .x(x2), .y(y2),
        .valid(v2), .hsync(hs2), .vsync(vs2), .vblank(vb2), .line_start(ls2),
        .frame_start(fs2), .frame_cnt(fc2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    int t;
    int n_hs0, n_val0, n_fs0, n_vs2, n_vs0, n_vb2, n_pe1, n_fs1, n_ls1, n_hold1;
    int first_hs0, first_vs2, n_hsline;
    logic [3:0] h1_prev;

    initial begin
        repeat (3) @(negedge pclk);
        chk("rst_h", h0, 14);
        chk("rst_v", vc0, 7);
        chk("rst_fc", fc0, 255);
        chk("rst_pix", pe0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_xy", {x0, y0}, 0);
        chk("rst_vblank", vb0, 1);
        chk("rst_pulses", {ls0, fs0}, 0);
        chk("rst_syncs", {hs0, vs0}, 2'b11);
        chk("rst_vs_pol1", vs2, 0);
        chk("rst_h_div2", h1, 14);
        reset = 1'b0;
        tick();
        t = 0;
        chk("first_h", h0, 0);
        chk("first_v", vc0, 0);
        chk("first_valid", v0, 1);
        chk("first_fs", fs0, 1);
        chk("first_ls", ls0, 1);
        chk("first_fc", fc0, 0);
        chk("first_pix", pe0, 1);
        chk("first_syncs", {hs0, vs0}, 2'b11);
        chk("div2_no_step", {pe1, h1}, {1'b0, 4'd14});
        n_hs0 = 0; n_val0 = 0; n_fs0 = 0; n_vs2 = 0; n_vs0 = 0; n_vb2 = 0;
        n_pe1 = 0; n_fs1 = 0; n_ls1 = 0; n_hold1 = 0; first_hs0 = -1; first_vs2 = -1; n_hsline = 0;
        h1_prev = h1;
        // Two frames of the divide-by-1 raster, one frame of the divide-by-2 raster.
        for (int i = 0; i < 240; i++) begin
            if (i > 0) begin
                tick();
                t++;
            end
            if (!hs0) begin
                n_hs0++;
                if (first_hs0 < 0) first_hs0 = t;
                if (h0 < 10 || h0 > 12) n_hsline++;
            end
            n_val0 += v0;
            n_fs0  += fs0;
            if (vs2) begin
                n_vs2++;
                if (first_vs2 < 0) first_vs2 = t;
            end
            n_vs0 += !vs0;
            n_vb2 += vb2;
            n_pe1 += pe1;
            n_fs1 += fs1;
            n_ls1 += ls1;
            if (!pe1 && h1 != h1_prev) n_hold1++;
            h1_prev = h1;
            if (t == 1) chk("div2_first_step", {pe1, fs1, h1}, {1'b1, 1'b1, 4'd0});
            if (t == 13) chk("xy_active", {x0, y0, v0}, {4'd0, 4'd0, 1'b0});
            if (t == 22) chk("xy_line1", {x0, y0, v0}, {4'd7, 4'd1, 1'b1});
            if (t == 120) chk("fc_frame1", {fs0, fc0}, {1'b1, 8'd1});
        end
        chk("hs_count", n_hs0, 48);
        chk("hs_first", first_hs0, 10);
        chk("hs_outside", n_hsline, 0);
        chk("valid_count", n_val0, 64);
        chk("fs_count", n_fs0, 2);
        chk("vs_pol1_count", n_vs2, 60);
        chk("vs_pol1_first", first_vs2, 75);
        chk("vs_pol0_count", n_vs0, 60);
        chk("vblank_count", n_vb2, 120);
        chk("div2_pix_count", n_pe1, 120);
        chk("div2_fs_count", n_fs1, 1);
        chk("div2_ls_count", n_ls1, 8);
        chk("div2_hold", n_hold1, 0);
        while (t < 120 * 255) begin
            tick();
            t++;
        end
        chk("fc_255", {fs0, fc0}, {1'b1, 8'd255});
        while (t < 120 * 256 - 1) begin
            tick();
            t++;
        end
        chk("fc_hold_255", {fs0, fc0}, {1'b0, 8'd255});
        tick();
        t++;
        chk("fc_wrap", {fs0, fc0}, {1'b1, 8'd0});
        repeat (35) begin
            tick();
            t++;
        end
        chk("pre_rst_pos", {h0, vc0}, {4'd5, 4'd2});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pos", {h0, vc0}, {4'd14, 4'd7});
        chk("mid_rst_valid", {v0, pe0, fs0}, 0);
        chk("mid_rst_syncs", {hs0, vs0, vs2}, 3'b110);
        chk("mid_rst_fc", fc0, 255);
        tick();
        chk("post_rst_first", {h0, vc0, fs0, fc0}, {4'd0, 4'd0, 1'b1, 8'd0});
        chk("post_rst_div2", {pe1, h1}, {1'b0, 4'd14});
        tick();
        chk("post_rst_div2_step", {pe1, fs1, h1, fc1}, {1'b1, 1'b1, 4'd0, 8'd0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
